// File: rtl/ex.sv
// Execute stage: ALU, HI/LO registers, iterative divider and data memory request.
module ex (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  input  logic [4:0]   id_load_bus,
  input  logic [2:0]   id_save_bus,
  output logic [77:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         ex_is_load,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_for_ex
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic [158:0] bus_r;
  logic [4:0]   load_r;
  logic [2:0]   save_r;
  logic         reg_update;

  // The register changes (load or bubble) unless both EX and MEM are stopped.
  assign reg_update = !stall[2] || !stall[3];

  // Input pipeline register: load, insert bubble, or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r  <= '0;
      load_r <= '0;
      save_r <= '0;
    end else if (!stall[2]) begin
      bus_r  <= id_to_ex_bus;
      load_r <= id_load_bus;
      save_r <= id_save_bus;
    end else if (!stall[3]) begin
      bus_r  <= '0;
      load_r <= '0;
      save_r <= '0;
    end
  end

  logic [31:0] pc, inst, rs_data, rt_data;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        data_ram_en, rf_we, sel_rf_res;
  logic [3:0]  data_ram_wen;
  logic [4:0]  rf_waddr;

  assign pc           = bus_r[158:127];
  assign inst         = bus_r[126:95];
  assign alu_op       = bus_r[94:83];
  assign sel_src1     = bus_r[82:80];
  assign sel_src2     = bus_r[79:76];
  assign data_ram_en  = bus_r[75];
  assign data_ram_wen = bus_r[74:71];
  assign rf_we        = bus_r[70];
  assign rf_waddr     = bus_r[69:65];
  assign sel_rf_res   = bus_r[64];
  assign rs_data      = bus_r[63:32];
  assign rt_data      = bus_r[31:0];

  logic [31:0] src1, src2, alu_res;

  // Operand selection and ALU (alu_op is one-hot, bit 11 = add)
  always_comb begin
    src1 = '0;
    if (sel_src1[0]) src1 = rs_data;
    else if (sel_src1[1]) src1 = pc;
    else if (sel_src1[2]) src1 = {27'd0, inst[10:6]};
    src2 = '0;
    if (sel_src2[0]) src2 = rt_data;
    else if (sel_src2[1]) src2 = {{16{inst[15]}}, inst[15:0]};
    else if (sel_src2[2]) src2 = 32'd8;
    else if (sel_src2[3]) src2 = {16'd0, inst[15:0]};
    alu_res = '0;
    if (alu_op[11]) alu_res = src1 + src2;
    else if (alu_op[10]) alu_res = src1 - src2;
    else if (alu_op[9]) alu_res = {31'd0, $signed(src1) < $signed(src2)};
    else if (alu_op[8]) alu_res = {31'd0, src1 < src2};
    else if (alu_op[7]) alu_res = src1 & src2;
    else if (alu_op[6]) alu_res = ~(src1 | src2);
    else if (alu_op[5]) alu_res = src1 | src2;
    else if (alu_op[4]) alu_res = src1 ^ src2;
    else if (alu_op[3]) alu_res = src2 << src1[4:0];
    else if (alu_op[2]) alu_res = src2 >> src1[4:0];
    else if (alu_op[1]) alu_res = $signed(src2) >>> src1[4:0];
    else if (alu_op[0]) alu_res = {src2[15:0], 16'd0};
  end

  logic is_special, is_div, is_divu, is_mult, is_multu;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;

  assign is_special = inst[31:26] == 6'd0;
  assign is_div     = is_special && inst[5:0] == 6'h1A;
  assign is_divu    = is_special && inst[5:0] == 6'h1B;
  assign is_mult    = is_special && inst[5:0] == 6'h18;
  assign is_multu   = is_special && inst[5:0] == 6'h19;
  assign is_mfhi    = is_special && inst[5:0] == 6'h10;
  assign is_mflo    = is_special && inst[5:0] == 6'h12;
  assign is_mthi    = is_special && inst[5:0] == 6'h11;
  assign is_mtlo    = is_special && inst[5:0] == 6'h13;

  div_state_t  state;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_next;
  logic [31:0] dvs_r, rs_abs, rt_abs, div_hi, div_lo;
  logic [32:0] rem_sh, diff;
  logic        neg_q, neg_r, dvz, done_flag, div_start, qbit;

  assign rs_abs    = (is_div && rs_data[31]) ? 32'd0 - rs_data : rs_data;
  assign rt_abs    = (is_div && rt_data[31]) ? 32'd0 - rt_data : rt_data;
  assign div_start = (state == IDLE) && (is_div || is_divu) && !done_flag;

  // acc holds {partial remainder, dividend bits shifting into quotient}
  assign rem_sh   = acc[63:31];
  assign diff     = rem_sh - {1'b0, dvs_r};
  assign qbit     = !diff[32];
  assign acc_next = {qbit ? diff[31:0] : rem_sh[31:0], acc[30:0], qbit};

  assign div_lo = dvz ? 32'hFFFF_FFFF : (neg_q ? 32'd0 - acc[31:0] : acc[31:0]);
  assign div_hi = dvz ? acc[63:32] : (neg_r ? 32'd0 - acc[63:32] : acc[63:32]);

  // Divider FSM: one restoring iteration per BUSY cycle, done_flag blocks re-issue of a held divide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      dvs_r     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvz       <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_start) begin
          state <= BUSY;
          cnt   <= 5'd31;
          acc   <= {32'd0, rs_abs};
          dvs_r <= rt_abs;
          neg_q <= is_div && (rs_data[31] ^ rt_data[31]);
          neg_r <= is_div && rs_data[31];
          dvz   <= rt_data == 32'd0;
        end
        BUSY: begin
          acc <= acc_next;
          if (cnt == 5'd0) state <= DONE;
          else cnt <= cnt - 5'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (reg_update) done_flag <= 1'b0;
      else if (state == DONE) done_flag <= 1'b1;
    end
  end

  assign stallreq_for_ex = div_start || (state == BUSY);

  logic [31:0] hi, lo;
  logic [63:0] prod_s, prod_u;

  // Operands extended to 64 bits so the truncated product is exact for both signednesses.
  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // HI/LO update from divide completion, multiply or move-to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE) begin
      hi <= div_hi;
      lo <= div_lo;
    end else if (is_mult) begin
      {hi, lo} <= prod_s;
    end else if (is_multu) begin
      {hi, lo} <= prod_u;
    end else if (is_mthi) begin
      hi <= rs_data;
    end else if (is_mtlo) begin
      lo <= rs_data;
    end
  end

  logic [31:0] addr, result;
  logic        is_mem, rf_we_o;
  logic [4:0]  waddr_o;

  assign addr    = rs_data + {{16{inst[15]}}, inst[15:0]};
  assign is_mem  = (|load_r) || (|save_r);
  assign rf_we_o = rf_we || is_mfhi || is_mflo;
  assign waddr_o = (is_mfhi || is_mflo) ? inst[15:11] : rf_waddr;

  // Result selection and store lane/byte-enable generation
  always_comb begin
    result = alu_res;
    if (is_mfhi) result = hi;
    else if (is_mflo) result = lo;
    else if (is_mem) result = addr;
    data_sram_wen   = 4'b0000;
    data_sram_wdata = rt_data;
    if (save_r[0]) begin
      data_sram_wen = 4'b1111;
    end else if (save_r[1]) begin
      data_sram_wen   = addr[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{rt_data[15:0]}};
    end else if (save_r[2]) begin
      data_sram_wen   = 4'b0001 << addr[1:0];
      data_sram_wdata = {4{rt_data[7:0]}};
    end
  end

  assign data_sram_en   = data_ram_en || is_mem;
  assign data_sram_addr = addr;
  assign ex_is_load     = |load_r;
  assign ex_to_rf_bus   = {rf_we_o, waddr_o, result};
  assign ex_to_mem_bus  = {pc, load_r, addr[1:0], rf_we_o, waddr_o, sel_rf_res, result};

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], data_ram_wen};

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage: ALU/store vector table plus divide, stall and reset sequences.
module tb_ex;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   stall;
  logic [158:0] bus;
  logic [4:0]   ld;
  logic [2:0]   sv;
  logic [77:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         ex_is_load, data_sram_en, stallreq_for_ex;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  int errors = 0;
  int checks = 0;

  ex dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(bus),
    .id_load_bus(ld), .id_save_bus(sv),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_rf_bus(ex_to_rf_bus),
    .ex_is_load(ex_is_load), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .stallreq_for_ex(stallreq_for_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string        name;
    logic [158:0] bus;
    logic [4:0]   ld;
    logic [2:0]   sv;
    logic [37:0]  exp_rf;
    logic         exp_en;
    logic [3:0]   exp_wen;
    logic [31:0]  exp_addr;
    logic [31:0]  exp_wdata;
    logic         exp_load;
  } vec_t;

  vec_t vt[$];

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic [11:0] op, input logic [2:0] s1,
                                       input logic [3:0] s2, input logic ram_en,
                                       input logic [3:0] ram_wen, input logic we,
                                       input logic [4:0] wa, input logic sel,
                                       input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ram_en, ram_wen, we, wa, sel, rs, rt};
  endfunction

  task automatic addv(input string name, input logic [158:0] b, input logic [4:0] l,
                      input logic [2:0] s, input logic [37:0] rf, input logic en,
                      input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic isld);
    vec_t v;
    v.name = name; v.bus = b; v.ld = l; v.sv = s; v.exp_rf = rf; v.exp_en = en;
    v.exp_wen = wen; v.exp_addr = addr; v.exp_wdata = wdata; v.exp_load = isld;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
    bus = mk(0, 32'h0000_2810, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ld = 0; sv = 0; stall = 0;
    step();
    chk({nm, "_hi"}, 78'(ex_to_rf_bus), 78'({1'b1, 5'd5, eh}));
    bus = mk(0, 32'h0000_3012, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk({nm, "_lo"}, 78'(ex_to_rf_bus), 78'({1'b1, 5'd6, el}));
  endtask

  // Loads a divide, then freezes the stage and counts cycles with stallreq_for_ex high.
  task automatic run_div(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt,
                         output int n);
    bus = mk(0, inst, 0, 0, 0, 0, 0, 0, 0, 0, rs, rt); ld = 0; sv = 0; stall = 0;
    step();
    stall = 6'b001100;
    n = 0;
    while (stallreq_for_ex && n < 100) begin
      n++;
      step();
    end
  endtask

  logic [158:0] b_addu, b_sub, b_lw;
  int n, restarts;

  initial begin
    b_addu = mk(32'h0040_0000, 32'h0000_1821, 12'h800, 3'b001, 4'b0001, 0, 0, 1, 5'd3, 0,
                32'h7FFF_FFFF, 32'h1);
    b_sub  = mk(32'h0040_0004, 32'h0000_2023, 12'h400, 3'b001, 4'b0001, 0, 0, 1, 5'd4, 0,
                32'd5, 32'd7);
    b_lw   = mk(32'h0040_0010, 32'h8C08_FFFC, 12'h000, 3'b000, 4'b0000, 1, 0, 1, 5'd8, 1,
                32'h100, 32'h0);

    addv("addu", b_addu, 0, 0, {1'b1, 5'd3, 32'h8000_0000}, 0, 0, 0, 0, 0);
    addv("sub", b_sub, 0, 0, {1'b1, 5'd4, 32'hFFFF_FFFE}, 0, 0, 0, 0, 0);
    addv("slt", mk(0, 32'h0000_282A, 12'h200, 3'b001, 4'b0001, 0, 0, 1, 5'd5, 0,
         32'hFFFF_FFFF, 32'h1), 0, 0, {1'b1, 5'd5, 32'h1}, 0, 0, 0, 0, 0);
    addv("sltu", mk(0, 32'h0000_282B, 12'h100, 3'b001, 4'b0001, 0, 0, 1, 5'd5, 0,
         32'hFFFF_FFFF, 32'h1), 0, 0, {1'b1, 5'd5, 32'h0}, 0, 0, 0, 0, 0);
    addv("and", mk(0, 32'h0000_3024, 12'h080, 3'b001, 4'b0001, 0, 0, 1, 5'd6, 0,
         32'hF0F0_F0F0, 32'hFF00_FF00), 0, 0, {1'b1, 5'd6, 32'hF000_F000}, 0, 0, 0, 0, 0);
    addv("nor", mk(0, 32'h0000_3027, 12'h040, 3'b001, 4'b0001, 0, 0, 1, 5'd6, 0,
         32'hF0F0_F0F0, 32'h0F0F_0000), 0, 0, {1'b1, 5'd6, 32'h0000_0F0F}, 0, 0, 0, 0, 0);
    addv("or", mk(0, 32'h0000_3025, 12'h020, 3'b001, 4'b0001, 0, 0, 1, 5'd6, 0,
         32'h1234_0000, 32'h0000_5678), 0, 0, {1'b1, 5'd6, 32'h1234_5678}, 0, 0, 0, 0, 0);
    addv("xor", mk(0, 32'h0000_3026, 12'h010, 3'b001, 4'b0001, 0, 0, 1, 5'd6, 0,
         32'hFFFF_0000, 32'h0F0F_0F0F), 0, 0, {1'b1, 5'd6, 32'hF0F0_0F0F}, 0, 0, 0, 0, 0);
    addv("sll", mk(0, 32'h0000_1100, 12'h008, 3'b100, 4'b0001, 0, 0, 1, 5'd2, 0,
         32'hFFFF_FFFF, 32'hF1), 0, 0, {1'b1, 5'd2, 32'h0000_0F10}, 0, 0, 0, 0, 0);
    addv("srl", mk(0, 32'h0000_1202, 12'h004, 3'b100, 4'b0001, 0, 0, 1, 5'd2, 0,
         32'h0, 32'h8000_0000), 0, 0, {1'b1, 5'd2, 32'h0080_0000}, 0, 0, 0, 0, 0);
    addv("sra", mk(0, 32'h0000_1203, 12'h002, 3'b100, 4'b0001, 0, 0, 1, 5'd2, 0,
         32'h0, 32'h8000_0000), 0, 0, {1'b1, 5'd2, 32'hFF80_0000}, 0, 0, 0, 0, 0);
    addv("lui", mk(0, 32'h3C02_1234, 12'h001, 3'b000, 4'b1000, 0, 0, 1, 5'd2, 0,
         32'h0, 32'h0), 0, 0, {1'b1, 5'd2, 32'h1234_0000}, 0, 0, 0, 0, 0);
    addv("addiu", mk(0, 32'h2402_FFF0, 12'h800, 3'b001, 4'b0010, 0, 0, 1, 5'd2, 0,
         32'h100, 32'h0), 0, 0, {1'b1, 5'd2, 32'h0000_00F0}, 0, 0, 0, 0, 0);
    addv("link", mk(32'hBFC0_0000, 32'h0C00_0000, 12'h800, 3'b010, 4'b0100, 0, 0, 1, 5'd31, 0,
         32'h0, 32'h0), 0, 0, {1'b1, 5'd31, 32'hBFC0_0008}, 0, 0, 0, 0, 0);
    addv("aluop0", mk(0, 32'h0000_0825, 12'h000, 3'b001, 4'b0001, 0, 0, 1, 5'd1, 0,
         32'd5, 32'd6), 0, 0, {1'b1, 5'd1, 32'h0}, 0, 0, 0, 0, 0);
    addv("sb3", mk(0, 32'hA000_0003, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1000_0000, 32'hAB), 0, 3'b100,
         {1'b0, 5'd0, 32'h1000_0003}, 1, 4'b1000, 32'h1000_0003, 32'hABAB_ABAB, 0);
    addv("sb1", mk(0, 32'hA000_0001, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1000_0000, 32'h1234_5678), 0,
         3'b100, {1'b0, 5'd0, 32'h1000_0001}, 1, 4'b0010, 32'h1000_0001, 32'h7878_7878, 0);
    addv("sh2", mk(0, 32'hA400_0002, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1000_0000, 32'h1234_ABCD), 0,
         3'b010, {1'b0, 5'd0, 32'h1000_0002}, 1, 4'b1100, 32'h1000_0002, 32'hABCD_ABCD, 0);
    addv("sh0", mk(0, 32'hA400_0000, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1000_0000, 32'h1234_ABCD), 0,
         3'b010, {1'b0, 5'd0, 32'h1000_0000}, 1, 4'b0011, 32'h1000_0000, 32'hABCD_ABCD, 0);
    addv("sw", mk(0, 32'hAC00_0004, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1000_0000, 32'hCAFE_F00D), 0,
         3'b001, {1'b0, 5'd0, 32'h1000_0004}, 1, 4'b1111, 32'h1000_0004, 32'hCAFE_F00D, 0);
    addv("lw", b_lw, 5'b00001, 0, {1'b1, 5'd8, 32'h0000_00FC}, 1, 4'b0000, 32'h0000_00FC, 0, 1);
    addv("lb", mk(0, 32'h8009_FFFF, 0, 0, 0, 1, 0, 1, 5'd9, 1, 32'h200, 32'h0), 5'b10000, 0,
         {1'b1, 5'd9, 32'h0000_01FF}, 1, 4'b0000, 32'h0000_01FF, 0, 1);

    // reset: outputs zero even with live inputs presented
    stall = 0; bus = b_addu; ld = 0; sv = 0;
    #2;
    chk("rst_rf_bus", 78'(ex_to_rf_bus), 78'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_bus", ex_to_mem_bus, 78'd0);
    chk("rst_outs", 78'({data_sram_en, data_sram_wen, data_sram_addr, stallreq_for_ex, ex_is_load}),
        78'd0);
    rst = 0;

    foreach (vt[i]) begin
      bus = vt[i].bus; ld = vt[i].ld; sv = vt[i].sv; stall = 0;
      step();
      chk({vt[i].name, "_rf"}, 78'(ex_to_rf_bus), 78'(vt[i].exp_rf));
      chk({vt[i].name, "_en_wen_ld"}, 78'({data_sram_en, data_sram_wen, ex_is_load}),
          78'({vt[i].exp_en, vt[i].exp_wen, vt[i].exp_load}));
      if (vt[i].ld != 0 || vt[i].sv != 0)
        chk({vt[i].name, "_addr"}, 78'(data_sram_addr), 78'(vt[i].exp_addr));
      if (vt[i].sv != 0)
        chk({vt[i].name, "_wdata"}, 78'(data_sram_wdata), 78'(vt[i].exp_wdata));
    end

    bus = b_lw; ld = 5'b00001; sv = 0; stall = 0;
    step();
    chk("lw_mem_bus", ex_to_mem_bus,
        {32'h0040_0010, 5'b00001, 2'b00, 1'b1, 5'd8, 1'b1, 32'h0000_00FC});

    // stall behaviour: bubble, then hold
    bus = b_addu; ld = 0; sv = 0; stall = 0;
    step();
    bus = b_sub; stall = 6'b000100;
    step();
    chk("bubble_rf", 78'(ex_to_rf_bus), 78'd0);
    chk("bubble_mem", ex_to_mem_bus, 78'd0);
    bus = b_addu; stall = 0;
    step();
    bus = b_sub; stall = 6'b001100;
    step();
    chk("hold_rf", 78'(ex_to_rf_bus), 78'({1'b1, 5'd3, 32'h8000_0000}));
    stall = 0;
    step();
    chk("release_rf", 78'(ex_to_rf_bus), 78'({1'b1, 5'd4, 32'hFFFF_FFFE}));

    // multiply and move-to
    bus = mk(0, 32'h0000_0018, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFD, 32'd5); stall = 0;
    step();
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    bus = mk(0, 32'h0000_0019, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFD, 32'd5);
    step();
    read_hilo("multu", 32'h0000_0004, 32'hFFFF_FFF1);
    bus = mk(0, 32'h0000_0011, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'd0);
    step();
    bus = mk(0, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0123_4567, 32'd0);
    step();
    read_hilo("mthilo", 32'hDEAD_BEEF, 32'h0123_4567);

    // signed divide -7 / 2, held afterwards without restart
    run_div(32'h0000_001A, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_stall_cycles", 78'(n), 78'd33);
    restarts = 0;
    repeat (6) begin
      restarts += int'(stallreq_for_ex);
      step();
    end
    chk("div_no_restart", 78'(restarts), 78'd0);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // unsigned divide by zero
    run_div(32'h0000_001B, 32'd5, 32'd0, n);
    chk("divu0_stall_cycles", 78'(n), 78'd33);
    read_hilo("divu0", 32'd5, 32'hFFFF_FFFF);

    // reset during iteration 10
    bus = mk(0, 32'h0000_001B, 0, 0, 0, 0, 0, 0, 0, 0, 32'd100, 32'd7); stall = 0;
    step();
    stall = 6'b001100;
    repeat (11) step();
    chk("mid_div_busy", 78'(stallreq_for_ex), 78'd1);
    rst = 1;
    #1;
    chk("mid_rst_stallreq", 78'(stallreq_for_ex), 78'd0);
    chk("mid_rst_rf", 78'(ex_to_rf_bus), 78'd0);
    @(posedge clk);
    #1;
    rst = 0;
    read_hilo("post_rst", 32'd0, 32'd0);

    // divider usable again after the reset: 100 / 7
    run_div(32'h0000_001B, 32'd100, 32'd7, n);
    chk("divu_stall_cycles", 78'(n), 78'd33);
    read_hilo("divu", 32'd2, 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex.md
EX -- requirements
Module: EX

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 stall  input  6  pipeline stall vector; bit=1 means Stop; bit 2 = EX, bit 3 = MEM.
REQ-004 id_to_ex_bus  input  159  fields, MSB first:
- pc[158:127], inst[126:95], alu_op[94:83]
- sel_src1[82:80], sel_src2[79:76]
- data_ram_en[75], data_ram_wen[74:71]
- rf_we[70], rf_waddr[69:65], sel_rf_res[64]
- rs_data[63:32], rt_data[31:0]
REQ-005 id_load_bus  input  5  {lb,lbu,lh,lhu,lw}.
REQ-006 id_save_bus  input  3  {sb,sh,sw}.
REQ-007 ex_to_mem_bus  output  78  {pc[32], load_bus[5], addr_lo[2], rf_we, rf_waddr[5], sel_rf_res, result[32]}.
REQ-008 ex_to_rf_bus  output  38  {rf_we, rf_waddr[5], result[32]}, forwarding path to ID.
REQ-009 ex_is_load  output  1  EX holds any load; used by ID for load-use stall.
REQ-010 data_sram_en / data_sram_wen / data_sram_addr / data_sram_wdata  output  1/4/32/32  data memory request.
REQ-011 stallreq_for_ex  output  1  EX requests pipeline freeze (divide in progress).

Function
REQ-012 Input register: the bus bundle SHALL be replaced by all-zero (bubble) when stall[2]=1 and stall[3]=0; it SHALL load the inputs when stall[2]=0; it SHALL hold otherwise.
REQ-013 src1 selection: rs_data if sel_src1[0]; pc if sel_src1[1]; zero-extended inst[10:6] if sel_src1[2].
REQ-014 src2 selection: rt_data if sel_src2[0]; sign-extended inst[15:0] if sel_src2[1]; 32'd8 if sel_src2[2]; zero-extended inst[15:0] if sel_src2[3].
REQ-015 alu_op bits [11:0] SHALL select, in order: add, sub, slt (signed), sltu, and, nor, or, xor, sll (src2<<src1[4:0]), srl, sra, lui (src2<<16).
- All arithmetic is modulo 2^32 with no overflow trap.
- When alu_op is all-zero, the ALU result is 0.
REQ-016 EX SHALL decode from inst (opcode 0): div 0x1A, divu 0x1B, mult 0x18, multu 0x19, mfhi 0x10, mflo 0x12, mthi 0x11, mtlo 0x13.
REQ-017 mfhi/mflo: result SHALL be HI/LO, with rf_we forced to 1 and rf_waddr forced to inst[15:11].
REQ-018 mult/multu: single-cycle 64-bit product of rs_data and rt_data; {HI,LO} SHALL be written each edge the instruction occupies EX.
REQ-019 mthi/mtlo: HI or LO SHALL be written from rs_data.
REQ-020 Divider FSM states:
- IDLE -> BUSY when div/divu is in EX and done_flag=0; stallreq_for_ex=1 combinationally in that cycle.
- BUSY: 32 restoring shift-subtract iterations on operand magnitudes, one quotient bit per cycle; stallreq_for_ex=1.
- BUSY -> DONE after the 32nd iteration.
- DONE: stallreq_for_ex=0; HI=remainder and LO=quotient written on the exit edge; set done_flag; -> IDLE.
REQ-021 done_flag SHALL clear whenever the input register loads or bubbles, so that a held divide never restarts.
REQ-022 Signed divide:
- quotient is negated if operand signs differ;
- remainder takes the sign of the dividend.
REQ-023 Divide by zero: quotient 0xFFFFFFFF and remainder = dividend (unsigned magnitudes); no trap.
REQ-024 Memory address: data_sram_addr = rs_data + sign-extended inst[15:0]; data_sram_en = data_ram_en OR any load/store bit.
REQ-025 Store byte enables use addr[1:0]:
- sw: wen=1111;
- sh: wen=0011 when addr[1]=0, 1100 when addr[1]=1;
- sb: wen=0001<<addr[1:0].
- data_sram_wdata is the byte or halfword replicated across the word.
- Loads: wen=0000.
REQ-026 Bus result: ALU, HI/LO, or address (for loads/stores) as selected. Output buses are combinational from the input register and FSM state.

Reset
REQ-027 rst SHALL asynchronously clear the input register, HI, LO, done_flag, and the divider datapath.
- FSM returns to IDLE, including when reset is asserted mid-divide.
- All outputs are 0 during reset.

Verification
REQ-028 addu (rs=0x7FFFFFFF, rt=1) -> ex_to_rf_bus = {1, rd, 0x80000000} one cycle after load.
REQ-029 div (rs=-7, rt=2) -> stallreq_for_ex high for exactly 33 cycles (IDLE + 32 BUSY), low in DONE; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; no restart while held.
REQ-030 divu by 0 (rs=5) -> LO=0xFFFFFFFF, HI=5.
REQ-031 sb at addr 0x...03 with rt=0x000000AB -> wen=1000, wdata=0xABABABAB; sh at addr 0x...02 -> wen=1100.
REQ-032 stall[2]=1 and stall[3]=0 -> next bus is all-zero with rf_we=0; stall[2]=1 and stall[3]=1 -> contents held.
REQ-033 rst asserted at iteration 10 of a divide -> immediately IDLE, stallreq_for_ex=0, HI=LO=0.
